cart_usb_arbiter: RTL and testbench

CART_USB_ARBITER -- requirements
Module: cart_usb_arbiter

---
 rtl/cart_usb_arbiter_if.sv | 54 +++++
 rtl/cart_usb_arbiter.sv | 145 ++++++++++++++
 tb/tb_cart_usb_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_usb_arbiter_if.sv
// Bundle of request/ack, translation-stage and block-RAM signals for cart_usb_arbiter.
//   master : arbiter side (takes requests, drives strobes, acks, RAM port)
//   slave  : environment side (requesters, translation stage, RAM)
// Cart/USB: req/we/addr[25:0]/wdata[15:0] in, ack/rdata[15:0] out.
// Translation: from_cart/from_usb/cart_usb_addr[25:0] out, compact_addr[18:0] in.
// RAM: mem_en/mem_we/mem_addr[18:0]/mem_wdata[15:0] out, mem_rdata[15:0] in.
interface cart_usb_arbiter_if;
  logic        cart_req;
  logic        cart_we;
  logic [25:0] cart_addr;
  logic [15:0] cart_wdata;
  logic        cart_ack;
  logic [15:0] cart_rdata;

  logic        usb_req;
  logic        usb_we;
  logic [25:0] usb_addr;
  logic [15:0] usb_wdata;
  logic        usb_ack;
  logic [15:0] usb_rdata;

  logic        from_cart;
  logic        from_usb;
  logic [25:0] cart_usb_addr;
  logic [18:0] compact_addr;

  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (
    input  cart_req, cart_we, cart_addr, cart_wdata,
    output cart_ack, cart_rdata,
    input  usb_req, usb_we, usb_addr, usb_wdata,
    output usb_ack, usb_rdata,
    output from_cart, from_usb, cart_usb_addr,
    input  compact_addr,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output cart_req, cart_we, cart_addr, cart_wdata,
    input  cart_ack, cart_rdata,
    output usb_req, usb_we, usb_addr, usb_wdata,
    input  usb_ack, usb_rdata,
    input  from_cart, from_usb, cart_usb_addr,
    output compact_addr,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/cart_usb_arbiter.sv
// cart_usb_arbiter: shares one block-RAM port between a cart requester and a USB requester.
// One transaction at a time: IDLE -> ISSUE (translation strobe) -> ACCESS (RAM enable)
// -> [RDWAIT for reads] -> DONE (ack pulse) -> IDLE.
// Cart has priority, but after STARVE_LIMIT consecutive cart grants with USB waiting,
// USB is granted.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cart_usb_arbiter_if.master (requests, translation stage, RAM port)
module cart_usb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  cart_usb_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StAccess,
    StRdWait,
    StDone
  } state_e;

  localparam logic [2:0] StarveLimit = 3'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        id_usb_q, id_usb_d;
  logic        we_q, we_d;
  logic [25:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cart_rdata_q, cart_rdata_d;
  logic [15:0] usb_rdata_q, usb_rdata_d;

  logic        any_req;
  logic        grant_usb;

  // USB wins only when cart is idle or cart has used up its starvation allowance.
  always_comb begin
    any_req   = bus.cart_req | bus.usb_req;
    grant_usb = bus.usb_req & (~bus.cart_req | (starve_q == StarveLimit));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction latches, starvation counter and read-data holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q     <= 3'd0;
      id_usb_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 26'd0;
      wdata_q      <= 16'd0;
      cart_rdata_q <= 16'd0;
      usb_rdata_q  <= 16'd0;
    end else begin
      starve_q     <= starve_d;
      id_usb_q     <= id_usb_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cart_rdata_q <= cart_rdata_d;
      usb_rdata_q  <= usb_rdata_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    id_usb_d     = id_usb_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cart_rdata_d = cart_rdata_q;
    usb_rdata_d  = usb_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d  = StIssue;
          id_usb_d = grant_usb;
          if (grant_usb) begin
            we_d     = bus.usb_we;
            addr_d   = bus.usb_addr;
            wdata_d  = bus.usb_wdata;
            starve_d = 3'd0;
          end else begin
            we_d    = bus.cart_we;
            addr_d  = bus.cart_addr;
            wdata_d = bus.cart_wdata;
            // Count only cart grants that made USB wait; saturate at 7.
            if (bus.usb_req) begin
              if (starve_q != 3'd7) begin
                starve_d = starve_q + 3'd1;
              end
            end else begin
              starve_d = 3'd0;
            end
          end
        end
      end
      StIssue:  state_d = StAccess;
      StAccess: state_d = we_q ? StDone : StRdWait;
      StRdWait: begin
        state_d = StDone;
        if (id_usb_q) begin
          usb_rdata_d = bus.mem_rdata;
        end else begin
          cart_rdata_d = bus.mem_rdata;
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; addr_q only changes on grant, so it doubles as
  // the held cart_usb_addr value.
  always_comb begin
    bus.from_cart     = (state_q == StIssue) & ~id_usb_q;
    bus.from_usb      = (state_q == StIssue) & id_usb_q;
    bus.cart_usb_addr = addr_q;

    bus.mem_en        = (state_q == StAccess);
    bus.mem_we        = (state_q == StAccess) & we_q;
    bus.mem_addr      = (state_q == StAccess) ? bus.compact_addr : 19'd0;
    bus.mem_wdata     = (state_q == StAccess) ? wdata_q : 16'd0;

    bus.cart_ack      = (state_q == StDone) & ~id_usb_q;
    bus.usb_ack       = (state_q == StDone) & id_usb_q;
    bus.cart_rdata    = cart_rdata_q;
    bus.usb_rdata     = usb_rdata_q;
  end

endmodule

// File: tb/tb_cart_usb_arbiter.sv
// Scoreboard bench for cart_usb_arbiter: stimulus pushes expected transactions,
// a negedge monitor pops and checks strobes, RAM accesses, acks and latencies.
module tb_cart_usb_arbiter;

  logic clk;
  logic rst_n;

  cart_usb_arbiter_if bus ();

  cart_usb_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          usb;
    bit          we;
    logic [25:0] addr;
    logic [18:0] caddr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  bit   busy;
  int   age;
  int   n_err;
  int   n_chk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Translation stage and RAM models.
  function automatic logic [18:0] xlate(input logic [25:0] a);
    if (a == 26'h1E00004) return 19'h62002;
    return a[19:1];
  endfunction

  function automatic logic [15:0] ram_rd(input logic [18:0] m);
    if (m == 19'h62002) return 16'h1234;
    return m[15:0] ^ 16'hA5A5;
  endfunction

  always @(posedge clk) begin
    if (bus.from_cart || bus.from_usb) bus.compact_addr <= xlate(bus.cart_usb_addr);
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram_rd(bus.mem_addr);
  end

  // Monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      if (busy) age++;
      if (bus.from_cart || bus.from_usb) begin
        chk("strobe_onehot", 32'(bus.from_cart & bus.from_usb), 32'd0);
        chk("strobe_while_busy", 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe_usb", 32'(bus.from_usb), 32'd0);
          chk("unexpected_strobe_cart", 32'(bus.from_cart), 32'd0);
        end else begin
          cur  = exp_q.pop_front();
          busy = 1'b1;
          age  = 0;
          chk("strobe_side", 32'(bus.from_usb), 32'(cur.usb));
          chk("strobe_addr", 32'(bus.cart_usb_addr), 32'(cur.addr));
        end
      end else if (busy) begin
        chk("addr_hold", 32'(bus.cart_usb_addr), 32'(cur.addr));
      end
      if (bus.mem_en) begin
        chk("mem_en_in_txn", 32'(busy), 32'd1);
        if (busy) begin
          chk("mem_en_cycle", 32'(age), 32'd1);
          chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
          chk("mem_addr", 32'(bus.mem_addr), 32'(cur.caddr));
          if (cur.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(cur.wdata));
        end
      end else begin
        chk("mem_we_idle", 32'(bus.mem_we), 32'd0);
      end
      if (bus.cart_ack || bus.usb_ack) begin
        chk("ack_onehot", 32'(bus.cart_ack & bus.usb_ack), 32'd0);
        chk("ack_in_txn", 32'(busy), 32'd1);
        if (busy) begin
          chk("ack_side", 32'(bus.usb_ack), 32'(cur.usb));
          chk("ack_latency", 32'(age), cur.we ? 32'd2 : 32'd3);
          if (!cur.we) begin
            chk("rdata", 32'(cur.usb ? bus.usb_rdata : bus.cart_rdata), 32'(cur.rdata));
          end
          busy = 1'b0;
        end
      end
    end
  end

  task automatic push(input bit usb, input bit we, input logic [25:0] a, input logic [18:0] ca,
                      input logic [15:0] wd, input logic [15:0] rd);
    txn_t t;
    t.usb = usb; t.we = we; t.addr = a; t.caddr = ca; t.wdata = wd; t.rdata = rd;
    exp_q.push_back(t);
  endtask

  task automatic drive(input bit usb, input bit req, input bit we, input logic [25:0] a,
                       input logic [15:0] wd);
    if (usb) begin
      bus.usb_req = req; bus.usb_we = we; bus.usb_addr = a; bus.usb_wdata = wd;
    end else begin
      bus.cart_req = req; bus.cart_we = we; bus.cart_addr = a; bus.cart_wdata = wd;
    end
  endtask

  // Waits on negedges for the side's ack, then drops that side's req.
  task automatic wait_ack(input bit usb, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = usb ? bus.usb_ack : bus.cart_ack;
    end
    chk(usb ? "usb_ack_seen" : "cart_ack_seen", 32'(seen), 32'd1);
    if (usb) bus.usb_req = 1'b0;
    else bus.cart_req = 1'b0;
  endtask

  task automatic wait_strobe(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = bus.from_cart | bus.from_usb;
    end
    chk("strobe_seen", 32'(seen), 32'd1);
  endtask

  task automatic single(input bit usb, input bit we, input logic [25:0] a, input logic [18:0] ca,
                        input logic [15:0] wd, input logic [15:0] rd);
    push(usb, we, a, ca, wd, rd);
    @(negedge clk);
    drive(usb, 1'b1, we, a, wd);
    wait_ack(usb, 20);
    @(negedge clk);
  endtask

  task automatic starve_round();
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 26'h40, 19'h20, 16'h1111, 16'h0);
    push(1'b1, 1'b1, 26'h80, 19'h40, 16'h2222, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 26'h40, 16'h1111);
    drive(1'b1, 1'b1, 1'b1, 26'h80, 16'h2222);
    wait_ack(1'b1, 60);
    bus.cart_req = 1'b0;
    @(negedge clk);
    chk("starve_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_from_cart", 32'(bus.from_cart), 32'd0);
    chk("rst_from_usb", 32'(bus.from_usb), 32'd0);
    chk("rst_cart_ack", 32'(bus.cart_ack), 32'd0);
    chk("rst_usb_ack", 32'(bus.usb_ack), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_cart_usb_addr", 32'(bus.cart_usb_addr), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_cart_rdata", 32'(bus.cart_rdata), 32'd0);
    chk("rst_usb_rdata", 32'(bus.usb_rdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_err = 0;
    n_chk = 0;
    busy  = 1'b0;
    age   = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 26'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 26'h0, 16'h0);
    bus.compact_addr = 19'h0;
    bus.mem_rdata    = 16'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cart write and USB read reference transactions.
    single(1'b0, 1'b1, 26'h0000010, 19'h00008, 16'hBEEF, 16'h0);
    single(1'b1, 1'b0, 26'h1E00004, 19'h62002, 16'h0, 16'h1234);

    // Cart read whose address input changes after grant.
    push(1'b0, 1'b0, 26'h100, 19'h80, 16'h0, 16'hA525);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 26'h100, 16'h0);
    wait_strobe(10);
    #2 bus.cart_addr = 26'h200;
    wait_ack(1'b0, 10);
    @(negedge clk);
    chk("usb_rdata_hold", 32'(bus.usb_rdata), 32'h1234);

    // Starvation: four cart grants, then USB; a second round proves the counter cleared.
    starve_round();
    starve_round();

    // USB request withdrawn while a cart write is in flight.
    push(1'b0, 1'b1, 26'h60, 19'h30, 16'h5555, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 26'h60, 16'h5555);
    wait_strobe(10);
    #2 bus.usb_req = 1'b1;
    @(negedge clk);
    bus.usb_req = 1'b0;
    wait_ack(1'b0, 10);
    repeat (6) @(negedge clk);

    // Reset during RDWAIT of a cart read: outputs clear at once, no late ack.
    push(1'b0, 1'b0, 26'h30, 19'h18, 16'h0, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 26'h30, 16'h0);
    wait_strobe(10);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.cart_req = 1'b0;
    busy = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Fresh write after the aborted read.
    single(1'b0, 1'b1, 26'h50, 19'h28, 16'hCAFE, 16'h0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
